// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: hex glyphs, blank pattern
// and a..h bit positions. All patterns here are active-high.
package seven_seg_pkg;

  // Segment bit positions within abcdefgh.
  localparam int unsigned SEG_A = 7;
  localparam int unsigned SEG_B = 6;
  localparam int unsigned SEG_C = 5;
  localparam int unsigned SEG_D = 4;
  localparam int unsigned SEG_E = 3;
  localparam int unsigned SEG_F = 2;
  localparam int unsigned SEG_G = 1;
  localparam int unsigned SEG_H = 0;

  // All segments and decimal point dark.
  localparam logic [7:0] SEG_OFF = 8'h00;

  // a..g glyphs indexed by nibble value; entry 15 is written first.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational nibble to a..g decoder (active-high).
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner with shadow/display double buffering,
// leading-zero blanking and optional digit PWM dimming.
// Build option: define SEVEN_SEG_SCAN_PWM_EN to add the brightness input,
// which gates the digit enable to the first (brightness+1)/16 of each slot.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 1024,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dots,
  input  logic                  load,
  input  logic                  blank_lz,
`ifdef SEVEN_SEG_SCAN_PWM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [7:0]            abcdefgh,
  output logic [N_DIGITS-1:0]   digit,
  output logic                  frame_done
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [7:0]          SEG_IDLE = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [N_DIGITS-1:0] DIG_IDLE = ACTIVE_LOW ? '1 : '0;

  logic [DIV_W-1:0]      div;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] shadow_v, disp_v;
  logic [N_DIGITS-1:0]   shadow_d, disp_d;

  logic                  div_tc, wrap;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_lz, blank;
  logic [N_DIGITS-1:0]   lz;
  logic [6:0]            seg7;
  logic [7:0]            seg_ah;
  logic [N_DIGITS-1:0]   dig_ah;
  logic                  dig_on;

  assign div_tc     = (div == DIV_W'(REFRESH_DIV - 1));
  assign wrap       = div_tc && (idx == IDX_W'(N_DIGITS - 1));
  assign frame_done = wrap && !rst;

  // Slot divider and scan index; reset restarts a full slot on digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
    end else if (div_tc) begin
      div <= '0;
      idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Shadow captures every load; display only picks it up at the frame wrap,
  // so a load on the wrap cycle shows from the frame after next.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_v <= '0;
      shadow_d <= '0;
      disp_v   <= '0;
      disp_d   <= '0;
    end else begin
      if (load) begin
        shadow_v <= value;
        shadow_d <= dots;
      end
      if (wrap) begin
        disp_v <= shadow_v;
        disp_d <= shadow_d;
      end
    end
  end

  // Leading-zero map: lz[i] set when nibbles N_DIGITS-1 down to i are zero.
  always_comb begin
    logic acc;
    acc = 1'b1;
    lz  = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      acc   = acc && (disp_v[4*i +: 4] == 4'h0);
      lz[i] = acc;
    end
  end

  // Select the scanned digit's nibble, dp and blanking state; one-hot enable.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    dig_ah  = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = disp_v[4*i +: 4];
        cur_dp    = disp_d[i];
        cur_lz    = lz[i];
        dig_ah[i] = 1'b1;
      end
    end
  end

  seven_seg_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (seg7)
  );

  assign blank  = blank_lz && (idx != '0) && cur_lz;
  assign seg_ah = {blank ? 7'b0 : seg7, cur_dp};

`ifdef SEVEN_SEG_SCAN_PWM_EN
  logic [31:0] pwm_thr;
  assign pwm_thr = ((32'(brightness) + 32'd1) * 32'(REFRESH_DIV)) >> 4;
  assign dig_on  = (32'(div) < pwm_thr);
`else
  assign dig_on  = 1'b1;
`endif

  // Registered drive: segments and digit move together one cycle after idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      abcdefgh <= SEG_IDLE;
      digit    <= DIG_IDLE;
    end else begin
      abcdefgh <= ACTIVE_LOW ? ~seg_ah : seg_ah;
      digit    <= ACTIVE_LOW ? ~(dig_on ? dig_ah : '0) : (dig_on ? dig_ah : '0);
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (N_DIGITS=4, REFRESH_DIV=16,
// ACTIVE_LOW=1) against a time-based reference model.
module tb_seven_seg_scan;

  localparam int N   = 4;
  localparam int RD  = 16;
  localparam int NRD = N * RD;

  logic        clk = 1'b0;
  logic        rst, load, blank_lz;
  logic [15:0] value;
  logic [3:0]  dots;
  logic [3:0]  brightness;
  logic [7:0]  abcdefgh;
  logic [3:0]  digit;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scan #(.N_DIGITS(N), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dots       (dots),
    .load       (load),
    .blank_lz   (blank_lz),
`ifdef SEVEN_SEG_SCAN_PWM_EN
    .brightness (brightness),
`endif
    .abcdefgh   (abcdefgh),
    .digit      (digit),
    .frame_done (frame_done)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: t counts non-reset edges since the last reset.
  int          t;
  logic [15:0] sh_v, dp_v;
  logic [3:0]  sh_d, dp_d;
  logic [7:0]  e_seg;
  logic [3:0]  e_dig;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  function automatic int pwm_thr();
`ifdef SEVEN_SEG_SCAN_PWM_EN
    return ((int'(brightness) + 1) * RD) / 16;
`else
    return RD;
`endif
  endfunction

  function automatic logic fd_due();
    return (t % NRD) == NRD - 1;
  endfunction

  // One clock: apply inputs, check outputs, advance the model over the edge.
  task automatic cyc(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] d);
    int slot, pos;
    logic blank;
    logic [7:0] ah;
    rst = r; load = ld; value = v; dots = d;
    #1;
    chk("frame_done", frame_done, !r && fd_due());
    chk("abcdefgh", abcdefgh, e_seg);
    chk("digit", digit, e_dig);
    if (r) begin
      t = 0; sh_v = '0; sh_d = '0; dp_v = '0; dp_d = '0;
      e_seg = 8'hFF; e_dig = 4'hF;
    end else begin
      slot  = (t / RD) % N;
      pos   = t % RD;
      blank = blank_lz && slot > 0 && ((dp_v >> (4 * slot)) == 16'h0);
      ah    = {blank ? 7'b0 : hex7(dp_v[4*slot +: 4]), dp_d[slot]};
      e_seg = ~ah;
      e_dig = (pos < pwm_thr()) ? ~(4'b0001 << slot) : 4'hF;
      if (fd_due()) begin dp_v = sh_v; dp_d = sh_d; end
      if (ld) begin sh_v = v; sh_d = d; end
      t++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, $urandom, $urandom);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dots = '0; blank_lz = 1'b0;
    brightness = 4'd15;
    t = 0; sh_v = '0; sh_d = '0; dp_v = '0; dp_d = '0;
    e_seg = 8'hFF; e_dig = 4'hF;
    @(posedge clk);
    @(negedge clk);

    // Reset held for three cycles: everything dark, no frame pulse.
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, '0, '0);

    // Load 12AF with dp on digit 2; new value only after the first wrap.
    cyc(1'b0, 1'b1, 16'h12AF, 4'b0100);
    idle(3 * NRD);

    // Leading-zero blanking on and off.
    blank_lz = 1'b1;
    cyc(1'b0, 1'b1, 16'h0005, 4'b0000);
    idle(2 * NRD);
    blank_lz = 1'b0;
    idle(NRD);

    // Load coinciding with the frame boundary.
    cyc(1'b0, 1'b1, 16'h0000, 4'b0000);
    for (int k = 0; k < NRD && !fd_due(); k++) cyc(1'b0, 1'b0, '0, '0);
    chk("fd_align", fd_due(), 1'b1);
    cyc(1'b0, 1'b1, 16'hFFFF, 4'b1111);
    idle(3 * NRD);

    // Reset pulse while digit 2 is being scanned.
    for (int k = 0; k < NRD && !((t / RD) % N == 2 && t % RD == 5); k++) idle(1);
    cyc(1'b1, 1'b0, '0, '0);
    cyc(1'b0, 1'b1, 16'h8421, 4'b0001);
    idle(2 * NRD);

`ifdef SEVEN_SEG_SCAN_PWM_EN
    brightness = 4'd3;
    idle(NRD);
    brightness = 4'd15;
    idle(NRD);
`endif

    // Randomized traffic, biased toward leading zeros.
    for (int k = 0; k < 2000; k++) begin
      logic [15:0] v;
      int z;
      v = 16'($urandom);
      z = $urandom_range(0, 4);
      if (z > 0) v = v & (16'hFFFF >> (4 * z));
      if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 149) == 0) brightness = 4'($urandom);
      cyc($urandom_range(0, 399) == 0, $urandom_range(0, 23) == 0, v, 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
